// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift-register family (serial-in chain and piso_tx).
`timescale 1ns/1ps
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Width of a down-counter that must hold WIDTH-1 (bits remaining minus one).
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register: write loads and sets full, read clears full; write wins.
`timescale 1ns/1ps
module piso_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            full  <= 1'b0;
        end else if (wr) begin
            // A simultaneous read has already taken the old word, so full stays set.
            rdata <= wdata;
            full  <= 1'b1;
        end else if (rd) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer for gapless streaming.
`timescale 1ns/1ps
module piso_tx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state, next_state;
    logic [WIDTH-1:0] shreg, shifted, hold_data;
    logic [CW-1:0]    cnt;
    logic             hold_full, hold_wr, hold_rd;
    logic             handshake, load_din, load_hold, do_shift;

    assign handshake = din_valid && din_ready;

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr    (hold_wr),
        .wdata (din),
        .rd    (hold_rd),
        .rdata (hold_data),
        .full  (hold_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        load_din   = 1'b0;
        load_hold  = 1'b0;
        do_shift   = 1'b0;
        hold_rd    = 1'b0;
        unique case (state)
            IDLE: begin
                if (handshake) begin
                    load_din   = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt != '0) begin
                        do_shift = 1'b1;
                    end else if (hold_full) begin
                        load_hold = 1'b1;
                        hold_rd   = 1'b1;
                    end else if (handshake) begin
                        load_din = 1'b1;    // bypass: new word goes straight to the shifter
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        hold_wr = handshake && (state == SHIFT) && !load_din;
    end

    assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_din) begin
            shreg <= din;
            cnt   <= LAST_CNT;
        end else if (load_hold) begin
            shreg <= hold_data;
            cnt   <= LAST_CNT;
        end else if (do_shift) begin
            shreg <= shifted;
            cnt   <= cnt - 1'b1;
        end
    end

    assign din_ready  = (state == IDLE) || !hold_full;
    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid && ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
    assign last       = sout_valid && (cnt == '0);
    assign busy       = sout_valid || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: stimulus pushes expected bits, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_piso_tx;

    typedef struct {
        logic b;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid, din_ready, en, sout, sout_valid, last, busy;
    logic [3:0] din;

    logic       l_valid, l_ready, l_en, l_sout, l_sout_valid, l_last, l_busy;
    logic [3:0] l_din;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];
    logic [31:0] cap;
    int         run, max_run;
    logic       saw_not_ready;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .en(en), .sout(sout), .sout_valid(sout_valid), .last(last), .busy(busy)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .din_valid(l_valid), .din_ready(l_ready), .din(l_din),
        .en(l_en), .sout(l_sout), .sout_valid(l_sout_valid), .last(l_last), .busy(l_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a bit is consumed at a posedge where sout_valid && en.
    initial begin
        logic prev_valid, prev_en, prev_sout, prev_last;
        exp_t e;
        prev_valid = 1'b0; prev_en = 1'b0; prev_sout = 1'b0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                run = 0;
            end else begin
                if (sout_valid && prev_valid && !prev_en) begin
                    check("stall_sout", 32'(sout), 32'(prev_sout));
                    check("stall_last", 32'(last), 32'(prev_last));
                end
                if (sout_valid && en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 32'(sout_valid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("sout", 32'(sout), 32'(e.b));
                        check("last", 32'(last), 32'(e.l));
                        cap = {cap[30:0], sout};
                    end
                end
                if (sout_valid && dut.hold_full)
                    check("hold_full_handshake", 32'(din_valid && din_ready), 32'(0));
                if (sout_valid && !din_ready) saw_not_ready = 1'b1;
                run = sout_valid ? run + 1 : 0;
                if (run > max_run) max_run = run;
                prev_valid = sout_valid; prev_en = en; prev_sout = sout; prev_last = last;
            end
        end
    end

    task automatic send_word(input logic [3:0] w);
        logic rdy;
        logic ok;
        ok = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rdy = din_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                for (int b = 3; b >= 0; b--) exp_q.push_back('{b: w[b], l: (b == 0)});
            end
        end
        #1;
        din_valid = 1'b0;
        din = 4'h0;
        if (!ok) check("handshake_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) check("drain_timeout", 32'(done), 32'(1));
    endtask

    initial begin
        int nv;
        rst = 1'b1; din_valid = 1'b0; din = 4'h0; en = 1'b0;
        l_valid = 1'b0; l_din = 4'h0; l_en = 1'b0;
        cap = '0; run = 0; max_run = 0; saw_not_ready = 1'b0;

        // Reset state, then five idle cycles with no change
        @(negedge clk);
        check("reset_outs", 32'({sout, sout_valid, last, busy, din_ready}), 32'(5'b00001));
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outs", 32'({sout, sout_valid, last, busy, din_ready}), 32'(5'b00001));
        end

        // Single word MSB first
        @(posedge clk); #1 en = 1'b1; cap = '0;
        send_word(4'b1011);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("idle_after_word", 32'({sout_valid, busy}), 32'(0));
        check("single_bits", cap[3:0], 32'(4'b1011));

        // LSB-first instance: 1011 goes out as 1,1,0,1
        @(posedge clk); #1 l_en = 1'b1; l_din = 4'b1011; l_valid = 1'b1;
        @(posedge clk); #1 l_valid = 1'b0;
        cap = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lsb_valid", 32'(l_sout_valid), 32'(1));
            check("lsb_last", 32'(l_last), 32'(i == 3));
            cap = {cap[30:0], l_sout};
        end
        check("lsb_bits", cap[3:0], 32'(4'b1101));
        @(negedge clk);
        check("lsb_idle", 32'(l_busy), 32'(0));

        // Back-to-back streaming with en high
        @(posedge clk); #1;
        cap = '0; max_run = 0; saw_not_ready = 1'b0;
        send_word(4'hA);
        send_word(4'h5);
        send_word(4'hF);
        wait_drain();
        check("b2b_bits", cap[11:0], 32'(12'hA5F));
        check("b2b_gapless", 32'(max_run), 32'(12));
        check("b2b_ready_drop", 32'(saw_not_ready), 32'(1));

        // Stalled en: pulse every third cycle, second word offered mid-stall
        @(posedge clk); #1 en = 1'b0; cap = '0;
        send_word(4'hC);
        fork
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1 en = (k % 3 == 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 send_word(4'h3);
            end
        join
        en = 1'b0;
        wait_drain();
        check("stall_bits", cap[7:0], 32'(8'hC3));

        // Reset mid-word with hold full
        @(posedge clk); #1;
        send_word(4'h9);
        send_word(4'h6);
        @(negedge clk);
        check("pre_reset_hold", 32'({busy, din_ready}), 32'(2'b10));
        @(posedge clk); #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1 en = 1'b0; rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midword_reset_outs", 32'({sout, sout_valid, last, busy, din_ready}), 32'(5'b00001));
        @(posedge clk); #1 rst = 1'b0; en = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sout_valid || sout) nv++;
        end
        check("no_resume_after_reset", 32'(nv), 32'(0));
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter, the transmit-side counterpart of the serial-in shift register chain. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock on `sout`, with frame and last-bit qualifiers. A one-word holding buffer lets the next word be accepted during shifting, so back-to-back words go out with no idle bit between them.

## Interface
- `WIDTH`, default 4: word width in bits; legal values are 2 or more.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `din_valid` in 1: parallel word offered.
- `din_ready` out 1: block can accept a word this cycle.
- `din` in WIDTH: parallel word; sampled on handshake (`din_valid && din_ready`).
- `en` in 1: bit strobe; advances the shifter by one bit when high.
- `sout` out 1: current serial bit.
- `sout_valid` out 1: `sout` carries a valid bit of a word.
- `last` out 1: `sout` is the final bit of the current word.
- `busy` out 1: shifter or holding buffer occupied.

## Operation
- State: `shreg[WIDTH-1:0]`, `cnt` (bits remaining minus 1, width clog2(WIDTH)), `hold[WIDTH-1:0]`, `hold_full`, and FSM state IDLE/SHIFT.
- Reset: state=IDLE, shreg=0, cnt=0, hold_full=0, hold=0.
- Outputs after reset: `sout`=0, `sout_valid`=0, `last`=0, `busy`=0, `din_ready`=1.
- `din_ready` = (state==IDLE) || !hold_full. It is a pure function of registers and does not depend on `din_valid`.
- `sout` = shreg[WIDTH-1] when MSB_FIRST, else shreg[0]. Forced to 0 in IDLE.
- `sout_valid` = (state==SHIFT). `last` = (state==SHIFT && cnt==0). `busy` = (state==SHIFT) || hold_full.

IDLE:
- On handshake: shreg<=din, cnt<=WIDTH-1, state->SHIFT.
- `en` is ignored.

SHIFT, `en`=1 with cnt>0:
- Shift shreg toward the output end and fill with 0.
- cnt<=cnt-1.

SHIFT, `en`=1 with cnt==0 (last bit consumed), in priority order:
- If hold_full: shreg<=hold, hold_full<=0, cnt<=WIDTH-1, stay in SHIFT.
- Else, if a handshake occurs in the same cycle: shreg<=din, cnt<=WIDTH-1, stay in SHIFT. The bypass skips the holding buffer.
- Else: state->IDLE.
- If hold_full and a handshake coincide: hold drains to shreg and the new word is written to hold, so hold_full stays 1. This is legal only because `din_ready` was 1, which requires hold_full=0. The combination is therefore unreachable; the bench asserts it never occurs.

SHIFT, handshake not consumed by the bypass:
- hold<=din, hold_full<=1.

SHIFT, `en`=0:
- Shifter holds; `sout`, `sout_valid` and `last` stay stable.
- Handshakes into hold are still accepted.

Other rules:
- `din` is never sampled without a handshake.
- Words are transmitted in acceptance order; none is dropped or duplicated.
- Reset mid-word aborts the word immediately and discards hold. No partial word resumes after reset.

## Timing
- Handshake at edge k in IDLE: `sout_valid`=1 and the first bit appears on `sout` after edge k (0-cycle wait for `en`).
- Each `en`-high edge advances one bit. A word occupies exactly WIDTH `en` edges.
- Gapless streaming: with `en` held high and a word always available, `sout_valid` stays 1 continuously at one bit per clock.
- `last` is high during exactly one bit time per word. That bit time is one cycle if `en` is high, and lasts until the next `en` edge otherwise.
- `din_ready` deasserts the edge after hold fills. It reasserts the edge after hold drains.

## Structure
- Shared package `shift_reg_pkg` holds:
  - the state enum `piso_state_t` with values IDLE and SHIFT;
  - a helper function for the `cnt` width (clog2).
- One sub-module: `piso_hold_buf`, a single-entry register with write, read, full flag and asynchronous reset. The top level owns the FSM, shifter and counter.

## Test plan
All scenarios use WIDTH=4 unless stated.
- Reset check: with `rst` asserted, `sout`=0, `sout_valid`=0, `last`=0, `busy`=0 and `din_ready`=1. Release, then idle for 5 cycles: outputs stay unchanged.
- Single word, MSB_FIRST=1: `din`=4'b1011, `en` held high → `sout` reads 1,0,1,1 over 4 cycles, `last` is high on the 4th bit only, and the block is in IDLE on the next cycle.
- LSB first: MSB_FIRST=0, `din`=4'b1011 → `sout` reads 1,1,0,1.
- Back-to-back with `en` high: words 4'hA, 4'h5 and 4'hF offered continuously.
  - `sout_valid` stays high for 12 cycles with no gap and the bits match all three words in order.
  - `din_ready` drops while hold is full.
- Stalled `en`: load 4'hC, then pulse `en` every third cycle.
  - `sout` and `last` hold steady between pulses.
  - A second word offered mid-stall is accepted into hold and sent next.
- Reset mid-word: assert `rst` after 2 bits of 4'h9 while hold contains 4'h6 → all outputs return to reset values and neither word's remaining bits ever appear on `sout`.
